// File: rtl/score_tracker.sv
// Score accumulator with combo multiplier, timeout decay, 14-bit saturation and session high score.
// Drives the display/BCD path: new_score is the conversion start strobe.
module score_tracker #(
   parameter int MAX_SCORE     = 9999,
   parameter int MAX_MULT      = 4,
   parameter int COMBO_TIMEOUT = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        game_rst,
   input  logic        catch,
   input  logic [3:0]  catch_pts,
   input  logic        miss,
   output logic [13:0] score,
   output logic        new_score,
   output logic [13:0] high_score,
   output logic        new_high,
   output logic [2:0]  mult,
   output logic        combo_on
);

   localparam int              TW         = (COMBO_TIMEOUT > 1) ? $clog2(COMBO_TIMEOUT) : 1;
   localparam logic [TW-1:0]   TIMER_LOAD = TW'(COMBO_TIMEOUT - 1);
   localparam logic [2:0]      MULT_TOP   = 3'(MAX_MULT);
   localparam logic [14:0]     SCORE_TOP  = 15'(MAX_SCORE);

   logic [13:0]   score_q, score_d;
   logic [13:0]   high_q, high_d;
   logic [2:0]    mult_q, mult_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          new_score_q, new_score_d;
   logic          new_high_q, new_high_d;
   logic          combo_q;

   logic          valid_catch;
   logic [5:0]    add;
   logic [14:0]   sum;
   logic [13:0]   sat_score;

   assign valid_catch = catch && (catch_pts != 4'd0);
   assign add         = 6'(catch_pts) * 6'(mult_q);
   assign sum         = {1'b0, score_q} + 15'(add);
   assign sat_score   = (sum > SCORE_TOP) ? SCORE_TOP[13:0] : sum[13:0];

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      score_d     = score_q;
      mult_d      = mult_q;
      timer_d     = timer_q;
      new_score_d = 1'b0;

      if (game_rst) begin
         score_d     = '0;
         mult_d      = 3'd1;
         timer_d     = '0;
         new_score_d = 1'b1;
      end else begin
         if (valid_catch) begin
            score_d     = sat_score;
            new_score_d = (sat_score != score_q);
            mult_d      = (mult_q < MULT_TOP) ? mult_q + 3'd1 : MULT_TOP;
            timer_d     = TIMER_LOAD;
         end
         // A miss in the same cycle still scores at the old multiplier, then breaks the combo.
         if (miss) begin
            mult_d  = 3'd1;
            timer_d = '0;
         end
         if (!catch && !miss && (mult_q > 3'd1)) begin
            if (timer_q == '0) mult_d = 3'd1;
            else               timer_d = timer_q - 1'b1;
         end
      end

      new_high_d = (score_d > high_q);
      high_d     = new_high_d ? score_d : high_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         score_q     <= '0;
         high_q      <= '0;
         mult_q      <= 3'd1;
         timer_q     <= '0;
         new_score_q <= 1'b0;
         new_high_q  <= 1'b0;
         combo_q     <= 1'b0;
      end else begin
         score_q     <= score_d;
         high_q      <= high_d;
         mult_q      <= mult_d;
         timer_q     <= timer_d;
         new_score_q <= new_score_d;
         new_high_q  <= new_high_d;
         combo_q     <= (mult_d > 3'd1);
      end
   end

   assign score      = score_q;
   assign new_score  = new_score_q;
   assign high_score = high_q;
   assign new_high   = new_high_q;
   assign mult       = mult_q;
   assign combo_on   = combo_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker with a short combo timeout (8 cycles).
module tb_score_tracker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        game_rst = 1'b0;
   logic        catch = 1'b0;
   logic [3:0]  catch_pts = 4'd0;
   logic        miss = 1'b0;
   logic [13:0] score;
   logic        new_score;
   logic [13:0] high_score;
   logic        new_high;
   logic [2:0]  mult;
   logic        combo_on;

   int n_pass = 0;
   int n_total = 0;

   score_tracker #(
      .MAX_SCORE(9999),
      .MAX_MULT(4),
      .COMBO_TIMEOUT(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .game_rst(game_rst),
      .catch(catch),
      .catch_pts(catch_pts),
      .miss(miss),
      .score(score),
      .new_score(new_score),
      .high_score(high_score),
      .new_high(new_high),
      .mult(mult),
      .combo_on(combo_on)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, advance one edge, sample 1 time unit later, then clear pulses.
   task automatic step(input logic c, input logic [3:0] p, input logic m, input logic g);
      catch = c; catch_pts = p; miss = m; game_rst = g;
      @(posedge clk); #1;
      catch = 1'b0; catch_pts = 4'd0; miss = 1'b0; game_rst = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      n_total++; if (score !== 14'd0)      $display("FAIL reset_score act=%0d exp=0", score); else n_pass++;
      n_total++; if (high_score !== 14'd0) $display("FAIL reset_high act=%0d exp=0", high_score); else n_pass++;
      n_total++; if (mult !== 3'd1)        $display("FAIL reset_mult act=%0d exp=1", mult); else n_pass++;
      n_total++; if (combo_on !== 1'b0)    $display("FAIL reset_combo act=%b exp=0", combo_on); else n_pass++;
      step(1'b0, 4'd0, 1'b0, 1'b0);
      n_total++; if ({new_score, new_high} !== 2'b00)
         $display("FAIL reset_strobes act=%b exp=00", {new_score, new_high}); else n_pass++;
   endtask

   task automatic test_combo_ramp();
      int exp_score [5] = '{5, 15, 30, 50, 70};
      int exp_mult  [5] = '{2, 3, 4, 4, 4};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd5, 1'b0, 1'b0);
         n_total++; if (score !== 14'(exp_score[i]))
            $display("FAIL ramp_score[%0d] act=%0d exp=%0d", i, score, exp_score[i]); else n_pass++;
         n_total++; if (mult !== 3'(exp_mult[i]))
            $display("FAIL ramp_mult[%0d] act=%0d exp=%0d", i, mult, exp_mult[i]); else n_pass++;
         n_total++; if ({new_score, new_high, combo_on} !== 3'b111)
            $display("FAIL ramp_strobes[%0d] act=%b exp=111", i, {new_score, new_high, combo_on}); else n_pass++;
         n_total++; if (high_score !== 14'(exp_score[i]))
            $display("FAIL ramp_high[%0d] act=%0d exp=%0d", i, high_score, exp_score[i]); else n_pass++;
      end
      step(1'b0, 4'd0, 1'b0, 1'b0);
      n_total++; if ({new_score, new_high} !== 2'b00)
         $display("FAIL ramp_idle_strobes act=%b exp=00", {new_score, new_high}); else n_pass++;
      n_total++; if (mult !== 3'd4) $display("FAIL ramp_idle_mult act=%0d exp=4", mult); else n_pass++;
   endtask

   task automatic test_miss();
      step(1'b0, 4'd0, 1'b1, 1'b0);
      n_total++; if (score !== 14'd70) $display("FAIL miss_score act=%0d exp=70", score); else n_pass++;
      n_total++; if ({mult, combo_on, new_score} !== {3'd1, 1'b0, 1'b0})
         $display("FAIL miss_state act=mult%0d/combo%b/ns%b exp=mult1/combo0/ns0", mult, combo_on, new_score);
      else n_pass++;
   endtask

   task automatic test_timeout();
      step(1'b0, 4'd0, 1'b0, 1'b1);
      n_total++; if ({score, new_score, new_high} !== {14'd0, 1'b1, 1'b0})
         $display("FAIL grst_state act=score%0d/ns%b/nh%b exp=score0/ns1/nh0", score, new_score, new_high);
      else n_pass++;
      n_total++; if (high_score !== 14'd70) $display("FAIL grst_high act=%0d exp=70", high_score); else n_pass++;
      step(1'b1, 4'd3, 1'b0, 1'b0);
      n_total++; if ({score, mult} !== {14'd3, 3'd2})
         $display("FAIL tmo_catch act=score%0d/mult%0d exp=score3/mult2", score, mult); else n_pass++;
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 4'd0, 1'b0, 1'b0);
         if (i < 8) begin
            n_total++; if ({mult, combo_on} !== {3'd2, 1'b1})
               $display("FAIL tmo_hold[%0d] act=mult%0d/combo%b exp=mult2/combo1", i, mult, combo_on); else n_pass++;
         end else begin
            n_total++; if ({mult, combo_on} !== {3'd1, 1'b0})
               $display("FAIL tmo_expire act=mult%0d/combo%b exp=mult1/combo0", mult, combo_on); else n_pass++;
         end
      end
   endtask

   task automatic test_zero_pts();
      step(1'b1, 4'd2, 1'b0, 1'b0);
      n_total++; if ({score, mult} !== {14'd5, 3'd2})
         $display("FAIL zero_pre act=score%0d/mult%0d exp=score5/mult2", score, mult); else n_pass++;
      step(1'b1, 4'd0, 1'b0, 1'b0);
      n_total++; if ({score, mult, new_score} !== {14'd5, 3'd2, 1'b0})
         $display("FAIL zero_pts act=score%0d/mult%0d/ns%b exp=score5/mult2/ns0", score, mult, new_score);
      else n_pass++;
   endtask

   task automatic test_catch_miss();
      step(1'b0, 4'd0, 1'b0, 1'b1);
      step(1'b1, 4'd10, 1'b0, 1'b0);  // 10
      step(1'b1, 4'd15, 1'b0, 1'b0);  // 40
      step(1'b1, 4'd15, 1'b0, 1'b0);  // 85, mult 4
      step(1'b0, 4'd0, 1'b1, 1'b0);   // mult 1
      step(1'b1, 4'd5, 1'b0, 1'b0);   // 90
      step(1'b1, 4'd5, 1'b0, 1'b0);   // 100, mult 3
      n_total++; if ({score, mult} !== {14'd100, 3'd3})
         $display("FAIL cm_pre act=score%0d/mult%0d exp=score100/mult3", score, mult); else n_pass++;
      step(1'b1, 4'd2, 1'b1, 1'b0);
      n_total++; if (score !== 14'd106) $display("FAIL cm_score act=%0d exp=106", score); else n_pass++;
      n_total++; if ({mult, combo_on, new_score} !== {3'd1, 1'b0, 1'b1})
         $display("FAIL cm_state act=mult%0d/combo%b/ns%b exp=mult1/combo0/ns1", mult, combo_on, new_score);
      else n_pass++;
      n_total++; if ({high_score, new_high} !== {14'd106, 1'b1})
         $display("FAIL cm_high act=%0d/nh%b exp=106/nh1", high_score, new_high); else n_pass++;
   endtask

   task automatic test_game_rst_catch();
      logic [3:0] pts [6] = '{4'd11, 4'd15, 4'd15, 4'd15, 4'd15, 4'd11};
      step(1'b0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, pts[i], 1'b0, 1'b0);
      n_total++; if ({score, high_score} !== {14'd250, 14'd250})
         $display("FAIL gc_pre act=score%0d/high%0d exp=score250/high250", score, high_score); else n_pass++;
      step(1'b1, 4'd9, 1'b0, 1'b1);
      n_total++; if ({score, high_score} !== {14'd0, 14'd250})
         $display("FAIL gc_score act=score%0d/high%0d exp=score0/high250", score, high_score); else n_pass++;
      n_total++; if ({new_score, new_high, mult} !== {1'b1, 1'b0, 3'd1})
         $display("FAIL gc_state act=ns%b/nh%b/mult%0d exp=ns1/nh0/mult1", new_score, new_high, mult); else n_pass++;
      step(1'b1, 4'd4, 1'b0, 1'b0);
      n_total++; if ({score, high_score, new_score, new_high} !== {14'd4, 14'd250, 1'b1, 1'b0})
         $display("FAIL gc_after act=score%0d/high%0d/ns%b/nh%b exp=score4/high250/ns1/nh0",
                  score, high_score, new_score, new_high);
      else n_pass++;
   endtask

   task automatic test_saturation();
      step(1'b0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 168; i++) step(1'b1, 4'd15, 1'b0, 1'b0);
      n_total++; if ({score, mult} !== {14'd9990, 3'd4})
         $display("FAIL sat_pre act=score%0d/mult%0d exp=score9990/mult4", score, mult); else n_pass++;
      step(1'b1, 4'd15, 1'b0, 1'b0);
      n_total++; if ({score, new_score} !== {14'd9999, 1'b1})
         $display("FAIL sat_clip act=score%0d/ns%b exp=score9999/ns1", score, new_score); else n_pass++;
      n_total++; if ({high_score, new_high} !== {14'd9999, 1'b1})
         $display("FAIL sat_high act=%0d/nh%b exp=9999/nh1", high_score, new_high); else n_pass++;
      step(1'b1, 4'd15, 1'b0, 1'b0);
      n_total++; if ({score, new_score, new_high} !== {14'd9999, 1'b0, 1'b0})
         $display("FAIL sat_hold act=score%0d/ns%b/nh%b exp=score9999/ns0/nh0", score, new_score, new_high);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_combo_ramp();
      test_miss();
      test_timeout();
      test_zero_pts();
      test_catch_miss();
      test_game_rst_catch();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Score-accumulation stage directly upstream of the score display and BCD converter.
- Receives catch/miss events from the egg logic and applies a combo multiplier that decays on a timeout.
- Outputs a saturating 14-bit score and a one-cycle new_score strobe; the strobe is the conversion start for the display path.
- Also holds the session high score.

Parameters:
- MAX_SCORE, 9999: saturation ceiling; must fit in 14 bits and in 4 BCD digits.
- MAX_MULT, 4: highest combo multiplier (1..7).
- COMBO_TIMEOUT, 50000000: cycles without a catch before the multiplier falls back to 1 (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- game_rst  in  1  one-cycle pulse: start new game (clears score, keeps high score)
- catch  in  1  one-cycle pulse: egg caught
- catch_pts  in  4  base points for this catch; sampled only when catch=1
- miss  in  1  one-cycle pulse: egg missed
- score  out  14  current score, registered
- new_score  out  1  one-cycle strobe; score changed on this edge
- high_score  out  14  highest score since reset, registered
- new_high  out  1  one-cycle strobe; high_score changed on this edge
- mult  out  3  current multiplier, registered, range 1..MAX_MULT
- combo_on  out  1  high when mult > 1

Behaviour:
- All state changes happen on the rising clk edge. reset is sampled only on that edge; reset=0 overrides everything.
- Reset values: score=0, high_score=0, mult=1, combo timer=0, new_score=0, new_high=0, combo_on=0.
- Priority per cycle: reset > game_rst > catch/miss > timer decay.
- game_rst:
  - score←0, mult←1, timer←0.
  - new_score=1 for one cycle, even if score was already 0, so the display refreshes.
  - high_score unchanged; catch and miss in the same cycle are ignored.
- catch with catch_pts≠0:
  - add = catch_pts × mult (6-bit, max 60). sum = score + add, formed in 15 bits.
  - score←min(sum, MAX_SCORE).
  - new_score=1 in the cycle score takes the new value, only if the value actually changed. At saturation no strobe is issued.
  - The multiplier used is the pre-edge mult. After the edge, mult←min(mult+1, MAX_MULT) and timer←COMBO_TIMEOUT−1.
- catch with catch_pts=0: fully ignored; no score change, no strobe, mult and timer untouched.
- miss: mult←1, timer←0; score unchanged; no strobe.
- catch and miss in the same cycle:
  - Score is added using the pre-edge mult.
  - Multiplier and timer then follow the miss (mult←1, timer←0).
- Timer decay: when mult>1 and there is no catch, miss or game_rst, the timer decrements each cycle. On the edge where the timer is 0, mult←1.
- Resulting latency: mult returns to 1 exactly COMBO_TIMEOUT cycles after the last catch edge.
- High score:
  - Compare the next score value against high_score every cycle.
  - If next score > high_score, high_score takes that value on the same edge as score, and new_high=1 for one cycle.
  - Equal does not update.
- Strobes are never asserted two cycles running unless qualifying events occur on consecutive cycles. Back-to-back catches produce back-to-back strobes.
- combo_on is a registered copy of (mult_next>1), aligned with mult.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → score=0, high_score=0, mult=1, combo_on=0, no strobes.
- Combo ramp: from reset, catch_pts=5 on 5 consecutive cycles.
  - score=5,15,30,50,70.
  - mult=2,3,4,4,4 after each edge.
  - new_score high 5 cycles; high_score tracks score; new_high high 5 cycles.
- Timeout (COMBO_TIMEOUT=8 in bench): one catch with pts=3 → score=3, mult=2. Idle → mult=2 for 7 further cycles, mult=1 on the 8th edge after the catch.
- Saturation: preload score=9990 via catches, mult=4, catch_pts=15 → score=9999 with one strobe; a further catch → score stays 9999, new_score=0.
- Simultaneous catch+miss at mult=3, pts=2, score=100 → score=106, mult=1, combo_on=0, new_score=1.
- game_rst with catch in the same cycle at score=250, high=250 → score=0, high_score=250, new_score=1, new_high=0, mult=1. A subsequent catch with pts=4 → score=4, high_score unchanged.
